// File: rtl/jk_seq_pkg.sv
// Shared types for the J/K flip-flop bank sequencer: controller states and
// the J/K drive modes understood by jk_encode.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2
  } state_t;

  // HOLD leaves the bank alone, LOAD forces a value, STEP toggles changed bits.
  typedef enum logic [1:0] {
    ENC_HOLD = 2'd0,
    ENC_LOAD = 2'd1,
    ENC_STEP = 2'd2
  } enc_mode_t;

endpackage

// File: rtl/jk_encode.sv
// Combinational map from a drive mode and a (current, next) value pair to the
// per-bit J/K controls of the bank.
import jk_seq_pkg::*;

module jk_encode #(
  parameter int WIDTH = 4
) (
  input  enc_mode_t        mode,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] nxt,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  always_comb begin
    j = '0;
    k = '0;
    case (mode)
      ENC_LOAD: begin
        j = nxt;
        k = ~nxt;
      end
      // Toggling only the differing bits keeps unchanged bits glitch-free.
      ENC_STEP: begin
        j = cur ^ nxt;
        k = cur ^ nxt;
      end
      default: begin
        j = '0;
        k = '0;
      end
    endcase
  end

endmodule

// File: rtl/jk_ff_async.sv
// Single J/K flip-flop sampling on the falling clock edge, with asynchronous
// active-low reset (to 0) and set (to 1); reset wins over set.
module jk_ff_async (
  input  logic clk,
  input  logic rst_n,
  input  logic set_n,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(negedge clk or negedge rst_n or negedge set_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (!set_n) begin
      q <= 1'b1;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_seq_ctrl.sv
// Rising-edge sequencer that loads, counts and holds a falling-edge J/K
// flip-flop bank, using the bank's Q feedback for terminal count and desync.
import jk_seq_pkg::*;

module jk_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             cont,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic             cont_q, cont_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  enc_mode_t        enc_mode;
  logic [WIDTH-1:0] enc_cur;
  logic [WIDTH-1:0] enc_nxt;
  logic [WIDTH-1:0] start_pt;
  logic [WIDTH-1:0] end_pt;

  assign start_pt = dir_q ? lo_q : hi_q;
  assign end_pt   = dir_q ? hi_q : lo_q;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cont_d   = cont_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    done_d   = 1'b0;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
    enc_mode = ENC_HOLD;
    enc_cur  = q_in;
    enc_nxt  = q_in;

    case (state_q)
      IDLE: begin
        if (start && !stop && (lo <= hi)) begin
          dir_d    = dir;
          cont_d   = cont;
          lo_d     = lo;
          hi_d     = hi;
          enc_mode = ENC_LOAD;
          enc_nxt  = dir ? lo : hi;
          state_d  = LOAD;
        end else if (start && (lo > hi)) begin
          err_d = 1'b1;
        end
      end

      // LOAD evaluates exactly like COUNT: the bank already holds the start point.
      LOAD, COUNT: begin
        if (stop) begin
          state_d = IDLE;
        end else if ((q_in < lo_q) || (q_in > hi_q)) begin
          err_d    = 1'b1;
          enc_mode = ENC_LOAD;
          enc_nxt  = start_pt;
          state_d  = LOAD;
        end else if (q_in == end_pt) begin
          if (!cont_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            wrap_d   = 1'b1;
            enc_mode = ENC_STEP;
            enc_nxt  = start_pt;
            state_d  = COUNT;
          end
        end else begin
          enc_mode = ENC_STEP;
          enc_nxt  = dir_q ? (q_in + One) : (q_in - One);
          state_d  = COUNT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  jk_encode #(
    .WIDTH (WIDTH)
  ) u_encode (
    .mode (enc_mode),
    .cur  (enc_cur),
    .nxt  (enc_nxt),
    .j    (j_d),
    .k    (k_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      cont_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      j_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cont_q  <= cont_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      j_q     <= j_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign j    = j_q;
  assign k    = k_q;
  assign busy = busy_q;
  assign done = done_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule
